wb_regfile: RTL and testbench

- Write-back end of the MEM/WB pipeline register.
- Consumes the W-stage bundle (ALU result, load data, destination register, PC+4) plus W-stage control.
- Selects the write-back result, commits it to the 32x32 integer register file, and serves decode-stage reads with same-cycle write-through bypass.
- Maintains a 64-bit retired-instruction counter for later CSR use.

---
 rtl/wb_regfile_pkg.sv | 19 +
 rtl/wb_regfile_if.sv | 35 +++
 rtl/wb_regfile_2r1w.sv | 48 ++++
 rtl/wb_regfile.sv | 53 +++++
 tb/tb_wb_regfile.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared write-back constants and result-select encoding
// Purpose: widths, register count, retire-counter width and the ResultSrc
// encoding shared by the write-back stage and the control unit.
// Ports: none (package).
package wb_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int CNTW       = 64;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_MEM  = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_RSVD = 2'b11
  } result_src_e;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - W-stage bundle and decode read-port interface
// Purpose: groups the MEM/WB inputs, decode read addresses and the
// register-file outputs so pipeline and write-back stage share one bundle.
// Ports: master = pipeline side (drives W-stage and Rs addresses),
//        slave  = wb_regfile side (drives RD1D/RD2D/ResultW/InstRetW).
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic                  RegWriteW;
  logic [1:0]            ResultSrcW;
  logic [XLEN-1:0]       ALUResultW;
  logic [XLEN-1:0]       ReadDataW;
  logic [REG_ADDR_W-1:0] RdW;
  logic [XLEN-1:0]       PCPlus4W;
  logic                  ValidW;
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [XLEN-1:0]       RD1D;
  logic [XLEN-1:0]       RD2D;
  logic [XLEN-1:0]       ResultW;
  logic [CNTW-1:0]       InstRetW;

  modport master (
    output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W,
           ValidW, Rs1D, Rs2D,
    input  RD1D, RD2D, ResultW, InstRetW
  );

  modport slave (
    input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W,
           ValidW, Rs1D, Rs2D,
    output RD1D, RD2D, ResultW, InstRetW
  );

endinterface

// File: rtl/wb_regfile_2r1w.sv
// rtl/wb_regfile_2r1w.sv - 32x32 register file, one write port, two bypassed read ports
// Purpose: storage for x1..x31 (x0 hardwired to zero) with same-cycle
// write-through so decode sees a value in the cycle it is being written.
// Ports: clk, reset (async active-low), we/waddr/wdata (write port),
//        raddr1/rdata1 and raddr2/rdata2 (combinational read ports).
module regfile_2r1w
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [XLEN-1:0]       rdata1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata2
);

  // x0 has no storage; index 0 is never read or written.
  logic [XLEN-1:0] regs [1:NREG-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 check comes first so a write to x0 can never leak through the bypass.
  always_comb begin
    rdata1 = '0;
    if (raddr1 == '0)                 rdata1 = '0;
    else if (we && (waddr == raddr1)) rdata1 = wdata;
    else                              rdata1 = regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 == '0)                 rdata2 = '0;
    else if (we && (waddr == raddr2)) rdata2 = wdata;
    else                              rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage: result select, register commit, retire count
// Purpose: picks the W-stage result, commits it to the register file,
// serves decode reads with bypass and counts retired instructions.
// Ports: clk, reset (async active-low), bus (wb_regfile_if.slave) carrying
//        the W-stage bundle, decode read addresses and RD1D/RD2D/ResultW/InstRetW.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic [XLEN-1:0] result;
  logic [CNTW-1:0] instret_q;
  logic            commit;

  // Reserved select yields zero so ResultW is never X downstream.
  always_comb begin
    result = '0;
    case (result_src_e'(bus.ResultSrcW))
      RESULT_ALU: result = bus.ALUResultW;
      RESULT_MEM: result = bus.ReadDataW;
      RESULT_PC4: result = bus.PCPlus4W;
      default:    result = '0;
    endcase
  end

  // A bubble (ValidW=0) must neither write nor bypass.
  assign commit = bus.RegWriteW & bus.ValidW;

  regfile_2r1w u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (commit),
    .waddr  (bus.RdW),
    .wdata  (result),
    .raddr1 (bus.Rs1D),
    .rdata1 (bus.RD1D),
    .raddr2 (bus.Rs2D),
    .rdata2 (bus.RD2D)
  );

  // Every valid W slot retires, whether or not it writes a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           instret_q <= '0;
    else if (bus.ValidW)  instret_q <= instret_q + CNTW'(1);
  end

  assign bus.ResultW  = result;
  assign bus.InstRetW = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic vld, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.RegWriteW  = we;
    bus.ValidW     = vld;
    bus.ResultSrcW = src;
    bus.ALUResultW = alu;
    bus.ReadDataW  = mem;
    bus.PCPlus4W   = pc4;
    bus.RdW        = rd;
    bus.Rs1D       = rs1;
    bus.Rs2D       = rs2;
  endtask

  logic [63:0] cnt_seq [3];

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    drive(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
    #2;
    check("reset_instret", bus.InstRetW, 64'h0);
    check("reset_rd1",     bus.RD1D, 64'h0);
    check("reset_rd2",     bus.RD2D, 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // Write x5 = DEADBEEF, visible through bypass before the edge.
    @(negedge clk);
    drive(1, 1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd5, 5'd6);
    #1;
    check("byp_x5_rd1",   bus.RD1D, 64'hDEADBEEF);
    check("byp_x5_rd2",   bus.RD2D, 64'h0);
    check("res_alu",      bus.ResultW, 64'hDEADBEEF);

    @(negedge clk);
    drive(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
    #1;
    check("store_x5",     bus.RD1D, 64'hDEADBEEF);
    check("store_x6",     bus.RD2D, 64'h0);
    check("instret_1",    bus.InstRetW, 64'd1);

    // Load result into x7, both ports bypass.
    @(negedge clk);
    drive(1, 1, 2'b01, 32'h0, 32'h12345678, 32'h0, 5'd7, 5'd7, 5'd7);
    #1;
    check("byp_x7_rd1",   bus.RD1D, 64'h12345678);
    check("byp_x7_rd2",   bus.RD2D, 64'h12345678);
    check("res_mem",      bus.ResultW, 64'h12345678);

    @(negedge clk);
    drive(0, 0, 2'b10, 32'h0, 32'h0, 32'h104, 5'd0, 5'd7, 5'd5);
    #1;
    check("res_pc4",      bus.ResultW, 64'h104);
    check("store_x7",     bus.RD1D, 64'h12345678);
    check("store_x5_b",   bus.RD2D, 64'hDEADBEEF);
    check("instret_2",    bus.InstRetW, 64'd2);
    bus.ResultSrcW = 2'b11;
    #1;
    check("res_rsvd",     bus.ResultW, 64'h0);

    // Write to x0 is discarded, also through the bypass.
    @(negedge clk);
    drive(1, 1, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
    #1;
    check("x0_before",    bus.RD1D, 64'h0);
    check("x0_other",     bus.RD2D, 64'hDEADBEEF);

    // Write x3 = AAAA0003, also leaves x0 check after the edge.
    @(negedge clk);
    drive(1, 1, 2'b00, 32'hAAAA0003, 32'h0, 32'h0, 5'd3, 5'd0, 5'd3);
    #1;
    check("x0_after",     bus.RD1D, 64'h0);
    check("instret_3",    bus.InstRetW, 64'd3);

    // Bubble targeting x3: no bypass, no write, no retire.
    @(negedge clk);
    drive(1, 0, 2'b00, 32'h55, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3);
    #1;
    check("bubble_nobyp", bus.RD1D, 64'hAAAA0003);
    check("instret_4",    bus.InstRetW, 64'd4);
    @(negedge clk);
    #1;
    check("bubble_nowr",  bus.RD2D, 64'hAAAA0003);
    check("bubble_nocnt", bus.InstRetW, 64'd4);

    // Asynchronous reset mid-run clears everything without a clock edge.
    @(negedge clk);
    drive(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_instret", bus.InstRetW, 64'h0);
    for (int r = 1; r < 32; r++) begin
      bus.Rs1D = 5'(r);
      bus.Rs2D = 5'(32 - r);
      #1;
      check($sformatf("arst_rd1_x%0d", r), bus.RD1D, 64'h0);
      check($sformatf("arst_rd2_x%0d", 32 - r), bus.RD2D, 64'h0);
    end
    drive(1, 1, 2'b00, 32'h99, 32'h0, 32'h0, 5'd9, 5'd9, 5'd5);
    #1;
    check("arst_bypass",  bus.RD1D, 64'h99);
    check("arst_x5",      bus.RD2D, 64'h0);
    @(negedge clk);
    drive(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd5);
    #1;
    check("arst_hold",    bus.InstRetW, 64'h0);
    reset = 1'b1;

    // Counter wrap from a preloaded value.
    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    #1;
    check("cnt_preload",  bus.InstRetW, 64'hFFFF_FFFF_FFFF_FFFE);
    bus.ValidW = 1'b1;
    cnt_seq[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    cnt_seq[1] = 64'h0;
    cnt_seq[2] = 64'h1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("cnt_wrap_%0d", k), bus.InstRetW, cnt_seq[k]);
    end
    bus.ValidW = 1'b0;
    @(negedge clk);
    #1;
    check("cnt_stop",     bus.InstRetW, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
